// File: rtl/pwm_seq_ctrl.sv
// Tone sequencer: plays a host-written table of (frequency code, duration) entries
// on 256-cycle PWM period boundaries and gates the PWM generator through pwm_en_o.
module pwm_seq_ctrl #(
    parameter int DEPTH = 16,
    parameter int DUR_W = 12,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic             clk_256M,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_addr,
    input  logic [2:0]       wr_freq,
    input  logic [DUR_W-1:0] wr_dur,
    input  logic [IW-1:0]    seq_last,
    input  logic             loop_i,
    input  logic             start,
    input  logic             stop,
    output logic [2:0]       freq_o,
    output logic             pwm_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [IW-1:0]    idx_o
);

    localparam logic [1:0]       ST_IDLE = 2'd0;
    localparam logic [1:0]       ST_PLAY = 2'd1;
    localparam logic [1:0]       ST_DONE = 2'd2;
    localparam logic [7:0]       PRD_MAX = 8'd255;
    localparam logic [DUR_W-1:0] REM_ONE = DUR_W'(1);
    localparam logic [IW-1:0]    IDX_ONE = IW'(1);

    logic [2:0]       tbl_freq_q [DEPTH];
    logic [DUR_W-1:0] tbl_dur_q  [DEPTH];

    logic [1:0]       state_q,  state_d;
    logic [7:0]       prd_q,    prd_d;
    logic [DUR_W-1:0] rem_q,    rem_d;
    logic [IW-1:0]    idx_q,    idx_d;
    logic [IW-1:0]    last_q,   last_d;
    logic [2:0]       freq_q,   freq_d;
    logic             en_q,     en_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic [IW-1:0]    fetch_idx_s;
    logic             fetch_s;

    // A zero duration still plays one full PWM period.
    function automatic logic [DUR_W-1:0] dur_min1(input logic [DUR_W-1:0] dur);
        if (dur == {DUR_W{1'b0}}) begin
            return REM_ONE;
        end else begin
            return dur;
        end
    endfunction

    // Table storage, deliberately outside reset so contents survive rst_n.
    always_ff @(posedge clk_256M) begin
        if (wr_en) begin
            tbl_freq_q[wr_addr] <= wr_freq;
            tbl_dur_q[wr_addr]  <= wr_dur;
        end
    end

    // Next-state and output computation for the sequencer.
    always_comb begin
        state_d     = state_q;
        prd_d       = prd_q;
        rem_d       = rem_q;
        idx_d       = idx_q;
        last_d      = last_q;
        freq_d      = freq_q;
        en_d        = en_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        fetch_s     = 1'b0;
        fetch_idx_s = {IW{1'b0}};

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = ST_PLAY;
                    last_d  = seq_last;
                    prd_d   = 8'd0;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    fetch_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PLAY: begin
                prd_d = prd_q + 8'd1;
                if (prd_q == PRD_MAX) begin
                    if (rem_q > REM_ONE) begin
                        rem_d = rem_q - REM_ONE;
                    end else if (idx_q != last_q) begin
                        fetch_s     = 1'b1;
                        fetch_idx_s = idx_q + IDX_ONE;
                    end else if (loop_i) begin
                        fetch_s     = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    rem_d = rem_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        if (fetch_s) begin
            idx_d  = fetch_idx_s;
            freq_d = tbl_freq_q[fetch_idx_s];
            rem_d  = dur_min1(tbl_dur_q[fetch_idx_s]);
        end else begin
            idx_d = idx_d;
        end

        // Abort overrides everything; freq and index are left frozen.
        if (stop) begin
            state_d = ST_IDLE;
            idx_d   = idx_q;
            freq_d  = freq_q;
            rem_d   = rem_q;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk_256M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            prd_q   <= 8'd0;
            rem_q   <= {DUR_W{1'b0}};
            idx_q   <= {IW{1'b0}};
            last_q  <= {IW{1'b0}};
            freq_q  <= 3'd0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prd_q   <= prd_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            freq_q  <= freq_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign freq_o   = freq_q;
    assign pwm_en_o = en_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign idx_o    = idx_q;

endmodule

// File: doc/pwm_seq_ctrl.md
# pwm_seq_ctrl

Tone sequencer that drives the frequency-select input of the ROM-based PWM generator. It holds a small table of (frequency code, duration) entries written by the host, then plays them in order. Each entry lasts an integer number of 256-cycle PWM periods. It optionally loops. It sits between the host/register interface and the PWM generator, gating the generator through `pwm_en_o`.

## Interface
- `DEPTH`, 16: number of table entries; index width `IW = log2(DEPTH)`.
- `DUR_W`, 12: duration field width, counted in PWM periods.

- `clk_256M`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `wr_en`  in  1: table write strobe.
- `wr_addr`  in  IW: table write index.
- `wr_freq`  in  3: frequency code to store; this is the generator's `freq` (address step = 1 << code).
- `wr_dur`  in  DUR_W: duration to store, in PWM periods.
- `seq_last`  in  IW: index of the last entry to play; sampled on accepted `start`.
- `loop_i`  in  1: repeat from entry 0 after the last entry; sampled live at each sequence end.
- `start`  in  1: start strobe.
- `stop`  in  1: abort strobe.
- `freq_o`  out  3: frequency code for the PWM generator.
- `pwm_en_o`  out  1: generator enable; intended to drive the generator's active-low reset.
- `busy_o`  out  1: sequence in progress.
- `done_o`  out  1: one-cycle pulse on normal completion.
- `idx_o`  out  IW: index of the entry currently playing.

## Operation
- Table: DEPTH × (3 + DUR_W) register file.
  - Synchronous write on `wr_en`; asynchronous read by the sequencer.
  - Not cleared by reset.
  - Writes are allowed in any state. A write to the entry currently playing does not alter the registered `freq_o` or the remaining count. It takes effect on that entry's next fetch.
- States: IDLE, PLAY, DONE.
- **IDLE.** `start=1` and `stop=0` causes a transition to PLAY on the next edge, with:
  - `idx <= 0`, `last <= seq_last`;
  - `freq_o <= tbl[0].freq`;
  - `rem <= max(tbl[0].dur, 1)` (a duration of 0 plays as 1);
  - `prd_cnt <= 0`.
- **PLAY.**
  - `prd_cnt` (8-bit) increments every cycle and wraps 255→0.
  - When `prd_cnt == 255` and `rem > 1`: `rem <= rem - 1`.
  - When `prd_cnt == 255` and `rem == 1`:
    - if `idx != last`: `idx <= idx + 1`, then fetch that entry (`freq_o`, `rem`) on the same edge;
    - else if `loop_i`: `idx <= 0` and fetch entry 0;
    - else go to DONE.
- **DONE.** Lasts exactly one cycle, then returns to IDLE.
- **stop.** Valid in any state; has priority over everything.
  - Next state is IDLE, with `pwm_en_o=0` and `busy_o=0` on the following cycle.
  - No `done_o` pulse.
  - `freq_o` and `idx_o` hold their last values.
- `start` while in PLAY or DONE is ignored.
- `seq_last` changes during PLAY are ignored.
- Arithmetic: `rem` is DUR_W bits and never decrements below 1. `idx` wraps only through the `last`/`loop_i` rule above.

## Timing
- Reset values: `freq_o=0`, `pwm_en_o=0`, `busy_o=0`, `done_o=0`, `idx_o=0`; internally `state=IDLE`, `prd_cnt=0`, `rem=0`.
- All outputs are registered.
- Start latency: `start` is sampled at edge N. From cycle N+1, `pwm_en_o=1`, `busy_o=1`, `freq_o=tbl[0].freq` and `prd_cnt=0`. The generator therefore leaves reset with its own counter aligned to `prd_cnt`.
- Entry length: exactly `max(dur,1) × 256` cycles. Entry changes occur on the edge after `prd_cnt == 255`, so a generator period is never split.
- Transitions between entries and loop wrap are gapless: `pwm_en_o` stays 1.
- Completion, for the last entry ending at edge M:
  - cycle M+1: state DONE, `done_o=1`, `pwm_en_o=0`, `busy_o=0`;
  - cycle M+2: `done_o=0`, state IDLE.
- `start` is accepted in the DONE cycle? No — it is ignored there. It is accepted from M+2.
- Simultaneous `start` and `stop` in IDLE: the state stays IDLE.
- Asynchronous reset mid-PLAY: all outputs go to their reset values immediately. Table contents are retained.

## Test plan
- Reset, then the table holds {0:(3,2), 1:(5,1)}, `seq_last=1`, `loop_i=0`, `start` at cycle 10 → required response:
  - `freq_o=3`, `pwm_en_o=1` from cycle 11;
  - `freq_o=5`, `idx_o=1` at cycle 523;
  - `done_o` high only at cycle 779;
  - `pwm_en_o=0` at cycle 779.
- Same table with `loop_i=1` → after entry 1, `idx_o=0` and `freq_o=3` at cycle 779, with `pwm_en_o` continuously 1 and no `done_o`.
- Entry 0 with `dur=0`, `seq_last=0` → the entry plays exactly 256 cycles, then `done_o` pulses.
- `stop` asserted 100 cycles into PLAY → the next cycle shows `pwm_en_o=0`, `busy_o=0`, no `done_o`. A `start` 2 cycles later restarts from `idx_o=0`.
- During entry 0, write entry 0 to (7,1) and assert `start` again → `freq_o` is unchanged and the second `start` is ignored. On loop back to entry 0, `freq_o=7`.
- Assert `rst_n` low mid-PLAY, release it, then `start` → outputs are 0 during reset and replay uses the retained table values.
